// File: rtl/jk_timer_pkg.sv
// Shared types and constants for the JK-flip-flop timer controller and its counter.
package jk_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // {J,K} encodings for a single JK flip-flop
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/jk_timer_ctrl_if.sv
// Control/status bundle between a register front-end (master) and the timer (slave).
interface jk_timer_ctrl_if #(
  parameter int unsigned WIDTH = 3
);
  logic             start;
  logic             stop;
  logic             periodic;
  logic             down;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output start, stop, periodic, down, limit,
    input  count, busy, tc, done
  );

  modport slave (
    input  start, stop, periodic, down, limit,
    output count, busy, tc, done
  );
endinterface

// File: rtl/jk_updown_counter.sv
// Synchronous up/down counter built from per-bit JK flip-flops with a toggle chain.
module jk_updown_counter
  import jk_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             down,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    logic [1:0] jk;
    logic       chain;
    q_d   = '0;
    jk    = JK_HOLD;
    chain = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (load) begin
        jk = load_val[i] ? JK_SET : JK_RESET;
      end else if (en && chain) begin
        jk = JK_TOGGLE;
      end else begin
        jk = JK_HOLD;
      end
      // JK characteristic equation: Q+ = J&~Q | ~K&Q
      q_d[i] = (jk[1] & ~q_q[i]) | (~jk[0] & q_q[i]);
      chain  = chain & ((down == DIR_DOWN) ? ~q_q[i] : q_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_timer_ctrl.sv
// Timer controller: start/stop FSM, latched run configuration, terminal decode and done pulse.
module jk_timer_ctrl
  import jk_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic           clk,
  input  logic           rst,
  jk_timer_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             periodic_q, periodic_d;
  logic             down_q, down_d;
  logic             done_q, done_d;

  logic             cnt_load, cnt_en;
  logic [WIDTH-1:0] cnt_load_val;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] terminal;
  logic             tc;

  assign terminal = (down_q == DIR_DOWN) ? '0 : limit_q;
  assign tc       = (state_q == RUN) && (count == terminal);

  always_comb begin
    state_d      = state_q;
    limit_d      = limit_q;
    periodic_d   = periodic_q;
    down_d       = down_q;
    done_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    cnt_load_val = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          limit_d      = bus.limit;
          periodic_d   = bus.periodic;
          down_d       = bus.down;
          cnt_load     = 1'b1;
          cnt_load_val = (bus.down == DIR_DOWN) ? bus.limit : '0;
          state_d      = RUN;
        end
      end
      RUN: begin
        // stop takes precedence over the terminal-count action
        if (bus.stop) begin
          state_d = IDLE;
        end else if (tc) begin
          if (periodic_q) begin
            cnt_load     = 1'b1;
            cnt_load_val = (down_q == DIR_DOWN) ? limit_q : '0;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      limit_q    <= '0;
      periodic_q <= 1'b0;
      down_q     <= DIR_UP;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      periodic_q <= periodic_d;
      down_q     <= down_d;
      done_q     <= done_d;
    end
  end

  jk_updown_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .down     (down_q),
    .q        (count)
  );

  assign bus.count = count;
  assign bus.busy  = (state_q == RUN);
  assign bus.tc    = tc;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_jk_timer_ctrl.sv
// Scoreboard bench: a cycle-level reference model queues expected outputs, a monitor compares.
module tb_jk_timer_ctrl;

  localparam int unsigned W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  jk_timer_ctrl_if #(.WIDTH(W)) bus ();

  jk_timer_ctrl #(
    .WIDTH(W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // expected {count[2:0], busy, tc, done}
  logic [5:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: run position k since start, count derived arithmetically
  int m_run = 0, m_k = 0, m_L = 0, m_per = 0, m_dn = 0, m_count = 0, m_done = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_k = 0; m_L = 0; m_per = 0; m_dn = 0; m_count = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_run == 0) begin
        if (bus.start) begin
          m_run = 1; m_k = 0; m_L = int'(bus.limit);
          m_per = int'(bus.periodic); m_dn = int'(bus.down);
        end
      end else if (bus.stop) begin
        m_run = 0;
      end else if (m_k == m_L) begin
        if (m_per != 0) m_k = 0;
        else begin
          m_run = 0; m_done = 1;
        end
      end else begin
        m_k = m_k + 1;
      end
      if (m_run != 0) m_count = (m_dn != 0) ? (m_L - m_k) : m_k;
    end
    exp_q.push_back({3'(m_count), m_run != 0, (m_run != 0) && (m_k == m_L), m_done != 0});
  end

  always @(negedge clk) begin
    logic [5:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.count, bus.busy, bus.tc, bus.done};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got count=%0d busy=%b tc=%b done=%b expected count=%0d busy=%b tc=%b done=%b",
                 $time, a[5:3], a[2], a[1], a[0], e[5:3], e[2], e[1], e[0]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic start_run(input int lim, input logic per, input logic dn);
    bus.limit    = W'(lim);
    bus.periodic = per;
    bus.down     = dn;
    bus.start    = 1'b1;
    cyc(1);
    bus.start    = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.periodic = 1'b0; bus.down = 1'b0; bus.limit = '0;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);

    start_run(5, 1'b0, 1'b0);      cyc(8);
    start_run(3, 1'b1, 1'b1);      cyc(10); pulse_stop(); cyc(2);
    start_run(7, 1'b1, 1'b0);      cyc(18); pulse_stop(); cyc(2);
    start_run(6, 1'b0, 1'b0);      cyc(2);  pulse_stop(); cyc(3);
    start_run(6, 1'b1, 1'b0);      cyc(6);  pulse_stop(); cyc(3);
    start_run(0, 1'b0, 1'b0);      cyc(3);
    start_run(0, 1'b1, 1'b0);      cyc(5);  pulse_stop(); cyc(2);
    start_run(6, 1'b0, 1'b0);      cyc(4);
    rst = 1'b1; cyc(1); rst = 1'b0; cyc(2);

    bus.stop = 1'b1;
    start_run(4, 1'b0, 1'b1);
    bus.stop = 1'b0;               cyc(2);
    start_run(7, 1'b0, 1'b0);      cyc(12);

    for (int i = 0; i < 500; i++) begin
      bus.start    = ($urandom_range(0, 5) == 0);
      bus.stop     = ($urandom_range(0, 15) == 0);
      bus.periodic = 1'($urandom_range(0, 1));
      bus.down     = 1'($urandom_range(0, 1));
      bus.limit    = W'($urandom_range(0, 7));
      rst          = ($urandom_range(0, 99) == 0);
      cyc(1);
    end
    rst = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    cyc(3);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_timer_ctrl.md
# jk_timer_ctrl

Programmable timer controller that sequences a WIDTH-bit synchronous JK-flip-flop counter. It adds start/stop control, up/down direction, a programmable terminal value, one-shot or periodic (auto-reload) modes, a terminal-count strobe and a completion pulse. It sits between a control/register interface and the counter datapath, and it is the only agent that loads, enables or stops the counter.

## Interface
- WIDTH, 3, counter width in bits (≥2)
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a count run; sampled only in IDLE
- stop  input  1  abort a run; sampled only in RUN
- periodic  input  1  1 = auto-reload at terminal, 0 = one-shot; latched at start
- down  input  1  1 = count down from limit to 0, 0 = count up from 0 to limit; latched at start
- limit  input  WIDTH  terminal value for up-counts, reload value for down-counts; latched at start
- count  output  WIDTH  current counter value
- busy  output  1  high while the state is RUN
- tc  output  1  terminal-count strobe: combinational, (state==RUN) && (count==terminal)
- done  output  1  registered one-cycle pulse on one-shot completion

## Operation
- Reset: state IDLE, count=0, busy=0, done=0, latched limit/mode/dir=0; tc=0 as a consequence. Reset mid-run aborts immediately with no done pulse.
- States: IDLE, RUN.
- IDLE + start: latch limit, periodic and down. Load count with 0 (up) or limit (down). Go to RUN. stop is ignored in IDLE.
- RUN, count≠terminal: count steps by 1 in the latched direction each cycle. Terminal is limit_q for up-counts and 0 for down-counts.
- RUN, count==terminal (tc=1): the next edge depends on mode.
  - Periodic: reload the initial value and stay in RUN.
  - One-shot: go to IDLE, hold count at terminal, and pulse done.
- RUN + stop: go to IDLE on the next edge, count holds its current value, no done pulse. stop beats the terminal action when both occur in the same cycle.
- start while in RUN is ignored. Changes to limit, periodic or down while in RUN have no effect until the next start.
- limit=0: terminal equals the initial value.
  - Periodic: tc stays high every cycle and count stays 0.
  - One-shot: done fires one cycle after the start edge.
- No wrap-around: terminal ≤ 2^WIDTH−1, so the counter never steps past it. Modulus is limit+1 in both directions.
- Datapath: every count bit is a JK flip-flop.
  - Step: J=K=toggle_i, where toggle_i = AND of lower bits (up) or AND of inverted lower bits (down). Bit 0 always toggles while stepping.
  - Load: J=d_i, K=~d_i.
  - Hold: J=K=0.

## Timing
- The start edge is edge N. After edge N: busy=1 and count=initial value.
- Up-count with limit L: count=k after edge N+k. tc is high during the cycle after edge N+L.
- One-shot: at edge N+L+1, busy falls and done rises for exactly one cycle; count stays at L.
- Periodic: count=0 again after edge N+L+1. tc period is L+1 cycles.
- Down-count: the same timing, mirrored (count=L−k after edge N+k).
- Stop sampled at edge M: after edge M, busy=0 and count holds the value it had before edge M.
- A new start is accepted in the cycle during which done is high, because the state is already IDLE.

## Structure
- Shared package jk_timer_pkg holds:
  - the state enum (IDLE, RUN);
  - constants for the JK encodings (HOLD=2'b00, RESET=2'b01, SET=2'b10, TOGGLE=2'b11);
  - direction constants (UP=0, DOWN=1).
- One sub-module, jk_updown_counter:
  - ports: WIDTH, clk, rst, load, load_val, en, down, q;
  - contains the per-bit JK flip-flops and the toggle-chain logic.
- jk_timer_ctrl contains the FSM, the latched configuration registers, terminal compare, tc decode and the done register.

## Test plan
- Reset, then start with limit=5, up, one-shot → count 0,1,2,3,4,5 on successive cycles; tc high only while count=5; done high for one cycle at the next edge; busy low; count holds 5.
- Start with limit=3, down, periodic → count 3,2,1,0,3,2,… with tc pulsing every 4 cycles; done never asserted.
- Start with limit=7, up, periodic (WIDTH=3, full range) → count 0..7 then 0; no value outside 0..7; tc only when count=7.
- Run with limit=6; assert stop at count=2, and separately stop coinciding with tc → IDLE next edge, count holds (2, respectively 6), done=0.
- limit=0 one-shot → done exactly one cycle after the start edge. limit=0 periodic → tc continuously high, count stays 0.
- Assert rst mid-run at count=4 → next edge count=0, busy=0, done=0. Start and stop pulsed in IDLE together → RUN entered. Start pulsed during RUN → no restart.
